// File: rtl/multi_pulse_sync_if.sv
// multi_pulse_sync_if
// Bundles the per-channel event, status and delivery signals of
// multi_pulse_sync. The master side drives event pulses and the
// counter clear; the slave side (the synchroniser) drives busy,
// drop counters and delivered pulses.
`timescale 1ns/1ps

interface multi_pulse_sync_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 8
);

  logic [CH_NUM-1:0]       data_high_i;
  logic                    drop_clr_i;
  logic [CH_NUM-1:0]       busy_o;
  logic [CH_NUM*CNT_W-1:0] drop_cnt_o;
  logic [CH_NUM-1:0]       data_low_o;

  modport master (
    output data_high_i,
    output drop_clr_i,
    input  busy_o,
    input  drop_cnt_o,
    input  data_low_o
  );

  modport slave (
    input  data_high_i,
    input  drop_clr_i,
    output busy_o,
    output drop_cnt_o,
    output data_low_o
  );

endinterface

// File: rtl/multi_pulse_sync.sv
// multi_pulse_sync
// Multi-channel pulse synchroniser moving single-cycle events from the
// fast clock (clk_high_i) to the slow clock (clk_low_i). Each channel
// runs a req/ack toggle handshake with a one-deep pending slot; a pulse
// that finds both the transfer and the pending slot occupied is dropped
// and counted, so events are never silently merged.
// Optional feature: define MULTI_PULSE_SYNC_DROP_CNT_EN to build the
// per-channel saturating drop counters and the drop_clr_i clear. Without
// it drop_cnt_o is tied to zero and drop_clr_i is ignored.
`timescale 1ns/1ps

module multi_pulse_sync #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk_high_i,
  input  logic                 clk_low_i,
  input  logic                 rst_i,
  multi_pulse_sync_if.slave    bus
);

  // Source domain state
  logic [CH_NUM-1:0]                   r_req;
  logic [CH_NUM-1:0]                   r_pend;
  logic [SYNC_STAGES-1:0][CH_NUM-1:0]  r_ackSync;

  // Destination domain state
  logic [SYNC_STAGES-1:0][CH_NUM-1:0]  r_reqSync;
  logic [CH_NUM-1:0]                   r_hist;
  logic [CH_NUM-1:0]                   r_out;

  // Source domain decode
  logic [CH_NUM-1:0] w_ackLast;
  logic [CH_NUM-1:0] w_inFlight;
  logic [CH_NUM-1:0] w_launch;
  logic [CH_NUM-1:0] w_pendNext;
  logic [CH_NUM-1:0] w_drop;

  assign w_ackLast  = r_ackSync[SYNC_STAGES-1];
  assign w_inFlight = r_req ^ w_ackLast;

  // Per channel: a free channel launches the pending pulse first (or the
  // new one if nothing is pending); whatever cannot launch fills the
  // pending slot, and a pulse finding the slot full is dropped.
  always_comb begin
    w_launch   = '0;
    w_pendNext = r_pend;
    w_drop     = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (!w_inFlight[c]) begin
        if (r_pend[c]) begin
          w_launch[c]   = 1'b1;
          w_pendNext[c] = bus.data_high_i[c];
        end else begin
          w_launch[c]   = bus.data_high_i[c];
        end
      end else if (bus.data_high_i[c]) begin
        if (r_pend[c]) begin
          w_drop[c]     = 1'b1;
        end else begin
          w_pendNext[c] = 1'b1;
        end
      end
    end
  end

  // Source side: toggle req on launch, track the pending slot and bring
  // the returning ack toggle into the fast domain.
  always_ff @(posedge clk_high_i or posedge rst_i) begin
    if (rst_i) begin
      r_req     <= '0;
      r_pend    <= '0;
      r_ackSync <= '0;
    end else begin
      r_req     <= r_req ^ w_launch;
      r_pend    <= w_pendNext;
      r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], r_hist};
    end
  end

  // Destination side: synchronise req, turn each toggle into a one-cycle
  // pulse, and keep the last seen level as the ack back to the source.
  always_ff @(posedge clk_low_i or posedge rst_i) begin
    if (rst_i) begin
      r_reqSync <= '0;
      r_hist    <= '0;
      r_out     <= '0;
    end else begin
      r_reqSync <= {r_reqSync[SYNC_STAGES-2:0], r_req};
      r_hist    <= r_reqSync[SYNC_STAGES-1];
      r_out     <= r_reqSync[SYNC_STAGES-1] ^ r_hist;
    end
  end

  assign bus.busy_o     = w_inFlight | r_pend;
  assign bus.data_low_o = r_out;

`ifdef MULTI_PULSE_SYNC_DROP_CNT_EN
  logic [CH_NUM-1:0][CNT_W-1:0] r_dropCnt;

  // Saturating drop counters; a clear in the same cycle as a drop still
  // counts that drop, so the counter restarts at one.
  always_ff @(posedge clk_high_i or posedge rst_i) begin
    if (rst_i) begin
      r_dropCnt <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (bus.drop_clr_i) begin
          r_dropCnt[c] <= w_drop[c] ? CNT_W'(1) : '0;
        end else if (w_drop[c] && (r_dropCnt[c] != {CNT_W{1'b1}})) begin
          r_dropCnt[c] <= r_dropCnt[c] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.drop_cnt_o = r_dropCnt;
`else
  logic w_unusedDrop;

  assign bus.drop_cnt_o = {(CH_NUM*CNT_W){1'b0}};
  assign w_unusedDrop   = bus.drop_clr_i ^ (^w_drop);
`endif

endmodule
